// File: rtl/decode_regfile_sext.sv
// Decode datapath: 8x16 register file (R0 = 0), 8->16 sign extend, PC+4 pipe reg.
// Optional REGBANK_BYPASS_EN forwards same-cycle write data onto the read ports.
module decode_regfile_sext (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        RegWrite,
    input  logic [2:0]  rs,
    input  logic [2:0]  rt,
    input  logic [2:0]  rd,
    input  logic [15:0] writeDat,
    input  logic [7:0]  addressjump,
    input  logic [15:0] PC4,
    output logic [15:0] readData1,
    output logic [15:0] readData2,
    output logic [15:0] extendedSignal,
    output logic [15:0] PC4_outpuID
);

    logic [7:0][15:0] rf;
    logic             wr_en;
    logic             fwd1;
    logic             fwd2;
    logic [15:0]      stored1;
    logic [15:0]      stored2;

    assign wr_en = RegWrite && (rd != 3'd0);

    // rf[0] is never written; reads of index 0 are forced to zero below.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf <= '0;
        end else if (wr_en) begin
            rf[rd] <= writeDat;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            PC4_outpuID <= '0;
        end else begin
            PC4_outpuID <= PC4;
        end
    end

    assign stored1 = (rs == 3'd0) ? 16'h0000 : rf[rs];
    assign stored2 = (rt == 3'd0) ? 16'h0000 : rf[rt];

`ifdef REGBANK_BYPASS_EN
    // Reset blocks writes, so it must also block forwarding.
    assign fwd1 = reset_n && wr_en && (rd == rs);
    assign fwd2 = reset_n && wr_en && (rd == rt);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign readData1      = fwd1 ? writeDat : stored1;
    assign readData2      = fwd2 ? writeDat : stored2;
    assign extendedSignal = {{8{addressjump[7]}}, addressjump};

endmodule

// File: tb/tb_decode_regfile_sext.sv
// Scoreboard bench for decode_regfile_sext: stimulus queues expected values,
// a monitor process pops and compares them against the sampled outputs.
`timescale 1ns/10ps
module tb_decode_regfile_sext;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        RegWrite;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [15:0] writeDat;
    logic [7:0]  addressjump;
    logic [15:0] PC4;
    logic [15:0] readData1;
    logic [15:0] readData2;
    logic [15:0] extendedSignal;
    logic [15:0] PC4_outpuID;

    typedef struct {
        int          sel;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   n_vec = 0;
    int   n_bad = 0;

    decode_regfile_sext dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .RegWrite       (RegWrite),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .writeDat       (writeDat),
        .addressjump    (addressjump),
        .PC4            (PC4),
        .readData1      (readData1),
        .readData2      (readData2),
        .extendedSignal (extendedSignal),
        .PC4_outpuID    (PC4_outpuID)
    );

    always #5 clock = ~clock;

    initial begin
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                exp_t        e;
                logic [15:0] act;
                e = sb.pop_front();
                case (e.sel)
                    0:       act = readData1;
                    1:       act = readData2;
                    2:       act = extendedSignal;
                    default: act = PC4_outpuID;
                endcase
                n_vec++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic chk(input int sel, input logic [15:0] exp,
                       input string name);
        exp_t e;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
        -> sample_ev;
        for (int i = 0; i < 10 && sb.size() != 0; i++) #0.01;
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: monitor timeout, got none expected %h",
                     name, exp);
            sb.delete();
        end
    endtask

    task automatic wr(input logic [2:0] idx, input logic [15:0] d);
        @(negedge clock);
        RegWrite = 1'b1;
        rd       = idx;
        writeDat = d;
        @(posedge clock);
        #1;
        RegWrite = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        RegWrite    = 1'b0;
        rs          = 3'd1;
        rt          = 3'd2;
        rd          = 3'd0;
        writeDat    = '0;
        addressjump = '0;
        PC4         = 16'h0040;
        repeat (2) @(negedge clock);
        #1;
        chk(0, 16'h0000, "reset_rd1");
        chk(1, 16'h0000, "reset_rd2");
        chk(3, 16'h0000, "reset_pc");
        @(negedge clock);
        reset_n = 1'b1;

        // Load R3, then async reset mid-cycle
        wr(3'd3, 16'h1234);
        rs = 3'd3;
        #1;
        chk(0, 16'h1234, "r3_loaded");
        chk(3, 16'h0040, "pc_before_rst");
        #1;
        reset_n = 1'b0;
        #1;
        chk(0, 16'h0000, "async_rst_rd1");
        chk(3, 16'h0000, "async_rst_pc");
        #1;
        reset_n = 1'b1;

        // Write/read R5 on both ports, then a disabled write
        wr(3'd5, 16'hBEEF);
        rs = 3'd5;
        rt = 3'd5;
        #1;
        chk(0, 16'hBEEF, "r5_rd1");
        chk(1, 16'hBEEF, "r5_rd2");
        @(negedge clock);
        RegWrite = 1'b0;
        rd       = 3'd5;
        writeDat = 16'h0001;
        @(posedge clock);
        #1;
        chk(0, 16'hBEEF, "r5_no_we");

        // Distinct ports
        wr(3'd7, 16'h8001);
        rt = 3'd7;
        #1;
        chk(0, 16'hBEEF, "r5_vs_r7_rd1");
        chk(1, 16'h8001, "r7_rd2");

        // R0 hardwired
        wr(3'd0, 16'hFFFF);
        rs = 3'd0;
        rt = 3'd0;
        #1;
        chk(0, 16'h0000, "r0_rd1");
        chk(1, 16'h0000, "r0_rd2");

        // Sign extension
        addressjump = 8'h7F;
        #1;
        chk(2, 16'h007F, "sext_7f");
        addressjump = 8'h80;
        #1;
        chk(2, 16'hFF80, "sext_80");
        addressjump = 8'hFF;
        #1;
        chk(2, 16'hFFFF, "sext_ff");
        addressjump = 8'h00;
        #1;
        chk(2, 16'h0000, "sext_00");
        addressjump = 8'h5A;
        #1;
        chk(2, 16'h005A, "sext_5a");

        // Same-cycle read of a register being written
        wr(3'd2, 16'h0011);
        @(negedge clock);
        RegWrite = 1'b1;
        rd       = 3'd2;
        rs       = 3'd2;
        rt       = 3'd2;
        writeDat = 16'h00AA;
        #1;
`ifdef REGBANK_BYPASS_EN
        chk(0, 16'h00AA, "bypass_rd1");
        chk(1, 16'h00AA, "bypass_rd2");
`else
        chk(0, 16'h0011, "nobypass_rd1");
        chk(1, 16'h0011, "nobypass_rd2");
`endif
        @(posedge clock);
        #1;
        RegWrite = 1'b0;
        #1;
        chk(0, 16'h00AA, "after_edge_rd1");

        // rd=0 never forwards
        @(negedge clock);
        RegWrite = 1'b1;
        rd       = 3'd0;
        rs       = 3'd0;
        writeDat = 16'h7777;
        #1;
        chk(0, 16'h0000, "r0_no_fwd");
        @(posedge clock);
        #1;
        RegWrite = 1'b0;

        // PC pipeline register
        @(negedge clock);
        PC4 = 16'h0004;
        @(posedge clock);
        #1;
        chk(3, 16'h0004, "pc_4");
        PC4 = 16'h0008;
        #1;
        chk(3, 16'h0004, "pc_hold");
        @(posedge clock);
        #1;
        chk(3, 16'h0008, "pc_8");

        #20;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
